// File: rtl/router_pkg.sv
// router_pkg: definitions shared by the router datapath and the router FSM.
//   DATA_W_DEFAULT : default byte width of the router datapath
//   ADDR_W         : width of the destination address field in the header
//   ADDR_INVALID   : destination address that never selects a FIFO
//   fsm_strobe_t   : one-hot state strobes driven by the router FSM
package router_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // At most one field is high in any cycle.
  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
  } fsm_strobe_t;

endpackage

// File: rtl/router_parity_calc.sv
// router_parity_calc: running XOR parity over a packet (header + payload),
// capture of the trailing parity byte, and the mismatch flag.
// Built only when ROUTER_REG_PARITY_CHK_EN is defined.
// Ports:
//   clock, resetn   : rising-edge clock, synchronous active-low reset
//   strobe_i        : FSM state strobes
//   pkt_valid_i     : source byte valid (low on the parity byte)
//   data_in_i       : source byte
//   header_byte_i   : latched header byte
//   parity_done_i   : registered "parity byte captured" flag
//   err_o           : internal parity != captured parity byte
module router_parity_calc
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  fsm_strobe_t       strobe_i,
  input  logic              pkt_valid_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [DATA_W-1:0] header_byte_i,
  input  logic              parity_done_i,
  output logic              err_o
);

  logic [DATA_W-1:0] internal_parity_q;
  logic [DATA_W-1:0] packet_parity_q;
  logic              err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      internal_parity_q <= '0;
      packet_parity_q   <= '0;
      err_q             <= 1'b0;
    end else begin
      if (strobe_i.detect_add) begin
        internal_parity_q <= '0;
      end else if (strobe_i.lfd_state) begin
        internal_parity_q <= internal_parity_q ^ header_byte_i;
      end else if (strobe_i.ld_state && pkt_valid_i && !strobe_i.full_state) begin
        // Bytes taken into the full-state holding register are counted here,
        // once, when they first arrive.
        internal_parity_q <= internal_parity_q ^ data_in_i;
      end

      if (strobe_i.detect_add) begin
        packet_parity_q <= '0;
      end else if (strobe_i.ld_state && !pkt_valid_i) begin
        packet_parity_q <= data_in_i;
      end

      // Compared one edge after parity_done so both operands are settled;
      // the result then holds until the next header.
      if (strobe_i.detect_add) begin
        err_q <= 1'b0;
      end else if (parity_done_i) begin
        err_q <= (internal_parity_q != packet_parity_q);
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router. Latches the header,
// steers the byte written into the selected FIFO, parks the byte that
// arrives while the FIFO is full, and reports parity status to the FSM.
// Optional feature macro: ROUTER_REG_PARITY_CHK_EN (parity check and err);
// when undefined, err is tied to 0.
// Ports:
//   clock, resetn         : rising-edge clock, synchronous active-low reset
//   pkt_valid, data_in    : source byte stream (pkt_valid low on parity byte)
//   fifo_full             : selected FIFO full
//   detect_add .. rst_int_reg : one-hot FSM state strobes
//   dout                  : byte to write into the FIFO
//   parity_done           : trailing parity byte captured
//   low_pkt_valid         : pkt_valid fell while in load-data
//   err                   : parity mismatch for the current packet
// All outputs are registered; no combinational input-to-output path.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  fsm_strobe_t strobe;
  assign strobe = '{detect_add:  detect_add,
                    lfd_state:   lfd_state,
                    ld_state:    ld_state,
                    laf_state:   laf_state,
                    full_state:  full_state,
                    rst_int_reg: rst_int_reg};

  logic [DATA_W-1:0] header_byte_q;
  logic [DATA_W-1:0] ffsb_q;
  logic [DATA_W-1:0] dout_q;
  logic              parity_done_q;
  logic              low_pkt_valid_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte_q   <= '0;
      ffsb_q          <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      // The invalid address never selects a FIFO, so the previous header
      // is kept rather than overwritten.
      if (strobe.detect_add && pkt_valid && (data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
        header_byte_q <= data_in;
      end

      if (strobe.lfd_state) begin
        dout_q <= header_byte_q;
      end else if (strobe.ld_state && !fifo_full) begin
        dout_q <= data_in;
      end else if (strobe.ld_state && fifo_full) begin
        ffsb_q <= data_in;
      end else if (strobe.laf_state) begin
        dout_q <= ffsb_q;
      end

      if (strobe.rst_int_reg) begin
        low_pkt_valid_q <= 1'b0;
      end else if (strobe.ld_state && !pkt_valid) begin
        low_pkt_valid_q <= 1'b1;
      end

      // Second set term covers a parity byte that was parked in ffsb and
      // is only written out from load-after-full.
      if (strobe.detect_add) begin
        parity_done_q <= 1'b0;
      end else if ((strobe.ld_state && !fifo_full && !pkt_valid) ||
                   (strobe.laf_state && low_pkt_valid_q && !parity_done_q)) begin
        parity_done_q <= 1'b1;
      end
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;

`ifdef ROUTER_REG_PARITY_CHK_EN
  router_parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .clock         (clock),
    .resetn        (resetn),
    .strobe_i      (strobe),
    .pkt_valid_i   (pkt_valid),
    .data_in_i     (data_in),
    .header_byte_i (header_byte_q),
    .parity_done_i (parity_done_q),
    .err_o         (err)
  );
`else
  // full_state only qualifies parity accumulation.
  logic unused_full_state;
  assign unused_full_state = strobe.full_state;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
module tb_router_reg;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         resetn;
  logic         pkt_valid;
  logic [W-1:0] data_in;
  logic         fifo_full;
  logic         detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [W-1:0] dout;
  logic         parity_done, low_pkt_valid, err;

  always #5 clock = ~clock;

  router_reg #(.DATA_W(W)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];        // bytes expected on dout, in write order
  logic [W-1:0] last_written;    // most recent byte written to the FIFO
  logic [W-1:0] hdr_latched;     // header the block should be holding
  logic [W-1:0] payload[16];

`ifdef ROUTER_REG_PARITY_CHK_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; fifo_full = 0;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // A byte going into the FIFO, possibly through the full path.
  task automatic load_byte(input logic [W-1:0] b, input logic pv, input bit full,
                           input string tag);
    logic [W-1:0] e;
    idle_inputs();
    ld_state = 1; pkt_valid = pv; data_in = b; fifo_full = full;
    step();
    if (!full) begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, dout, e);
      last_written = e;
    end else begin
      check({tag, "_hold"}, dout, last_written);
      idle_inputs();
      full_state = 1; pkt_valid = 1; data_in = W'($urandom_range(0, 255));
      step();
      check({tag, "_fullhold"}, dout, last_written);
      idle_inputs();
      laf_state = 1; data_in = W'($urandom_range(0, 255));
      step();
      e = exp_q.pop_front();
      check({tag, "_laf_dout"}, dout, e);
      last_written = e;
    end
  endtask

  // Whole packet. full_mode: 0 never full, 1 full on first payload byte,
  // 2 random. Parity byte is the true XOR unless use_par is set.
  task automatic send_packet(input logic [W-1:0] hdr, input int len, input int full_mode,
                             input bit use_par, input logic [W-1:0] par_in, input string tag);
    logic [W-1:0] acc;
    logic [W-1:0] par;
    bit           full;
    bit           exp_err;
    idle_inputs();
    detect_add = 1; pkt_valid = 1; data_in = hdr;
    step();
    if (hdr[1:0] != 2'b11) hdr_latched = hdr;
    check({tag, "_hdr_err_clr"}, W'(err), W'(0));
    check({tag, "_hdr_pd_clr"}, W'(parity_done), W'(0));

    acc = hdr_latched;
    for (int i = 0; i < len; i++) acc ^= payload[i];
    par = use_par ? par_in : acc;
    exp_err = PARITY_BUILT && (acc != par);

    exp_q.push_back(hdr_latched);
    for (int i = 0; i < len; i++) exp_q.push_back(payload[i]);
    exp_q.push_back(par);

    idle_inputs();
    lfd_state = 1; pkt_valid = 1; data_in = W'($urandom_range(0, 255));
    step();
    last_written = exp_q.pop_front();
    check({tag, "_lfd_dout"}, dout, last_written);

    for (int i = 0; i < len; i++) begin
      full = (full_mode == 1 && i == 0) || (full_mode == 2 && $urandom_range(0, 2) == 0);
      load_byte(payload[i], 1'b1, full, {tag, "_pl"});
    end

    full = (full_mode == 2) && ($urandom_range(0, 2) == 0);
    load_byte(par, 1'b0, full, {tag, "_par"});
    check({tag, "_pd_set"}, W'(parity_done), W'(1));
    check({tag, "_lpv_set"}, W'(low_pkt_valid), W'(1));

    // Check-parity cycle: err becomes valid here.
    idle_inputs();
    pkt_valid = 0;
    step();
    check({tag, "_err"}, W'(err), W'(exp_err));
    check({tag, "_pd_hold"}, W'(parity_done), W'(1));

    idle_inputs();
    rst_int_reg = 1;
    step();
    check({tag, "_lpv_clr"}, W'(low_pkt_valid), W'(0));
    check({tag, "_err_hold"}, W'(err), W'(exp_err));
    idle_inputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    pkt_valid = 0; data_in = '0; resetn = 0;
    hdr_latched = '0; last_written = '0;
    step(); step();
    check("rst_dout", dout, '0);
    check("rst_pd", W'(parity_done), W'(0));
    check("rst_lpv", W'(low_pkt_valid), W'(0));
    check("rst_err", W'(err), W'(0));
    resetn = 1;
    step();

    // Good parity: 05, A5, A0.
    payload[0] = 8'hA5;
    send_packet(8'h05, 1, 0, 1'b1, 8'hA0, "good");

    // Bad parity; its err is cleared by the next header (checked there).
    send_packet(8'h05, 1, 0, 1'b1, 8'h00, "bad");

    // Full path with 3C parked while the FIFO is full.
    payload[0] = 8'h3C;
    send_packet(8'h05, 1, 1, 1'b0, 8'h00, "full");

    // Invalid address: header stays 05 and is what lfd emits.
    payload[0] = 8'h11; payload[1] = 8'h22;
    send_packet(8'h07, 2, 0, 1'b0, 8'h00, "badaddr");

    // Reset in the middle of a packet with non-zero running parity.
    idle_inputs();
    detect_add = 1; pkt_valid = 1; data_in = 8'h0A;
    step();
    idle_inputs();
    lfd_state = 1;
    step();
    idle_inputs();
    ld_state = 1; pkt_valid = 1; data_in = 8'h5F;
    step();
    ld_state = 1; pkt_valid = 0; data_in = 8'h33; resetn = 0;
    step();
    check("midrst_dout", dout, '0);
    check("midrst_err", W'(err), W'(0));
    check("midrst_pd", W'(parity_done), W'(0));
    check("midrst_lpv", W'(low_pkt_valid), W'(0));
    resetn = 1;
    idle_inputs();
    hdr_latched = '0;
    exp_q.delete();
    step();
    payload[0] = 8'h9E;
    send_packet(8'h02, 1, 0, 1'b0, 8'h00, "post_rst");

    // Randomized packets: random header, length, full events, parity errors.
    for (int p = 0; p < 40; p++) begin
      logic [W-1:0] h;
      int           n;
      bit           corrupt;
      h = W'($urandom_range(0, 255));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) payload[i] = W'($urandom_range(0, 255));
      corrupt = ($urandom_range(0, 3) == 0);
      send_packet(h, n, 2, corrupt, W'($urandom_range(0, 255)), "rand");
    end

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
